// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_frame_if.sv
// Handshake and line signals of the frame transmitter.
interface serial_tx_frame_if #(
    parameter int unsigned NBITS_DATA = 4
);

    logic [NBITS_DATA-1:0] data_in;
    logic                  load;
    logic                  ready;
    logic                  serial_out;
    logic                  busy;
    logic                  done;

    // Producer of words; observes the line and status.
    modport master (
        output data_in,
        output load,
        input  ready,
        input  serial_out,
        input  busy,
        input  done
    );

    // The transmitter itself.
    modport slave (
        input  data_in,
        input  load,
        output ready,
        output serial_out,
        output busy,
        output done
    );

endinterface

// File: rtl/serial_tx_frame_bit_timer.sv
// Down-counter that paces each line level to BIT_CYCLES clock cycles.
module bit_timer
    import serial_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned TW = clog2_min1(BIT_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Reload on restart, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = RELOAD;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/serial_tx_frame.sv
// Frame transmitter: start bit, data LSB-first, optional even parity, stop bit.
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int unsigned NBITS_DATA = 4,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic               clk_2,
    input  logic               reset_n,
    serial_tx_frame_if.slave   tx
);

    localparam int unsigned CW = clog2_min1(NBITS_DATA + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS_DATA - 1);

    tx_state_t             state_q, state_d;
    logic [NBITS_DATA-1:0] shreg_q, shreg_d;
    logic                  parity_q, parity_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tick;
    logic                  restart;

    // Timer is held at its reload value while idle, and reloaded whenever a level ends.
    assign restart = (state_q == IDLE) || tick;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state, shift register and parity capture.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tx.load) begin
                    state_d   = START;
                    shreg_d   = tx.data_in;
                    parity_d  = ^tx.data_in;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    // Logical shift keeps this legal for a one-bit word.
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight.
    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        tx.serial_out = LINE_IDLE;
        unique case (state_q)
            IDLE:    tx.serial_out = LINE_IDLE;
            START:   tx.serial_out = START_BIT;
            DATA:    tx.serial_out = shreg_q[0];
            PARITY:  tx.serial_out = parity_q;
            STOP:    tx.serial_out = STOP_BIT;
            default: tx.serial_out = LINE_IDLE;
        endcase
        tx.ready = (state_q == IDLE);
        tx.busy  = (state_q != IDLE);
        tx.done  = (state_q == STOP) && tick;
    end

endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
Parallel-in/serial-out frame transmitter. It is the sending end for the 4-bit serial shift register, which shifts in at the MSB and moves toward the LSB.
A parallel word is accepted by handshake, then driven on a single line as a frame: start bit, data bits LSB-first, optional even parity, stop bit.
On the board, SWI supplies the data and load inputs. serial_out drives an LED and feeds the receiver in loopback.

Parameters:
NBITS_DATA, 4, data word width (1..16).
BIT_CYCLES, 1, clk_2 cycles per serial bit (>=1; default 1 because clk_2 is already slow).
PARITY_EN, 1, 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
clk_2  input  1  system clock; all logic on its rising edge.
reset_n  input  1  synchronous reset, active-low.
data_in  input  NBITS_DATA  word to transmit; sampled only on acceptance.
load  input  1  request to send data_in (valid).
ready  output  1  high only in IDLE; the transfer is accepted on load && ready at a clock edge.
serial_out  output  1  serial line; idles high.
busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
done  output  1  one-cycle pulse during the final cycle of the stop bit.

Behaviour:
- Reset: reset_n=0 at a clock edge gives the following on the next cycle:
  - state=IDLE, serial_out=1, ready=1, busy=0, done=0.
  - Shift register and bit timer cleared.
- Reset has priority over every other event. Reset mid-frame abandons the frame: no done pulse, line returns high immediately.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered or decoded from registered state; no combinational path from load/data_in to serial_out.
- IDLE: serial_out=1, ready=1.
  - On load=1, the next state is START.
  - At the same edge: shreg <= data_in, parity <= ^data_in, bit counter <= 0, timer <= BIT_CYCLES-1.
- Bit timer: down-counter, loaded with BIT_CYCLES-1 on each state or bit entry. A tick fires when it reaches 0. Each line level is held exactly BIT_CYCLES cycles.
- START: serial_out=0. On tick, go to DATA.
- DATA: serial_out=shreg[0]. On tick, shift right (shreg <= {1'b0, shreg[NBITS_DATA-1:1]}) and increment the bit counter.
  - After bit NBITS_DATA-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: serial_out=parity (even parity: the total count of 1s across data and parity is even). On tick, go to STOP.
- STOP: serial_out=1, done=1 in the final cycle. On tick, go to IDLE.
- Frame length: BIT_CYCLES*(NBITS_DATA+2+PARITY_EN) cycles. The default is 7 cycles.
  - Back-to-back frames: at least one IDLE cycle (line high) between frames, because acceptance happens only in IDLE.
- load while busy is ignored; there is no queueing. data_in changes after acceptance have no effect on the frame in flight.
- load held high continuously: a new frame is accepted on every IDLE cycle, so the period is frame length + 1.
- Counter widths: bit counter $clog2(NBITS_DATA+1); timer $clog2(BIT_CYCLES+1), minimum 1 bit. No wrap is reachable in legal operation.

Decomposition:
- Package serial_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
  - The same package is shared with the receiver.
- One sub-module, bit_timer: parameter BIT_CYCLES; inputs clk_2, reset_n, restart; output tick.
- The FSM, shift register and parity logic stay in serial_tx_frame.

Test Plan:
- Default parameters, data_in=4'b1011, load pulsed 1 cycle in IDLE -> serial_out over the next 7 cycles = 0,1,1,0,1,1,1; busy=1 for those 7 cycles; done=1 on cycle 7; ready=1 again on cycle 8.
- data_in=4'b0000 -> line = 0,0,0,0,0,0,1 (parity 0); with PARITY_EN=0 -> line = 0,0,0,0,0,1 and done on cycle 6.
- BIT_CYCLES=3, data_in=4'b0101 -> each level held 3 cycles: 000 111 000 111 000 000 111, 21 cycles total; done only in cycle 21.
- Accept 4'b1111, then at cycle 3 change data_in to 4'b0000 and pulse load -> frame unaffected (0,1,1,1,1,0,1), the second load is ignored, ready stays 0.
- Reset mid-frame: reset_n=0 for 1 cycle at cycle 4 of a frame -> next cycle serial_out=1, busy=0, ready=1, no done pulse; a following load sends a complete, correct frame.
- Loopback into the 4-bit shift receiver, clocked in DATA cycles only, sending 4'b1001 then 4'b0110 -> the receiver holds 1001, then 0110; load held high gives an 8-cycle frame period.
